// File: rtl/ysyx_22050019_csr_pkg.sv
// Shared encodings for the CSR sequencer: type-bit indices, SYSTEM opcode fields and FSM states.
// The optional immediate forms are enabled by defining YSYX_22050019_CSR_IMM_EN.
package ysyx_22050019_csr_pkg;

   localparam int XLEN = 64;

   localparam int CSR_T_CSRRW = 0;
   localparam int CSR_T_ECALL = 1;
   localparam int CSR_T_CSRRS = 2;
   localparam int CSR_T_MRET  = 3;

   localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0]  F3_CSRRW  = 3'b001;
   localparam logic [2:0]  F3_CSRRS  = 3'b010;
   localparam logic [2:0]  F3_CSRRWI = 3'b101;
   localparam logic [2:0]  F3_CSRRSI = 3'b110;

   localparam logic [31:0] INST_ECALL = 32'h0000_0073;
   localparam logic [31:0] INST_MRET  = 32'h3020_0073;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } csr_state_e;

endpackage

// File: rtl/ysyx_22050019_csr_dec.sv
// Combinational CSR/system instruction decoder: instruction -> type strobe, CSR write, rd, illegal.
// Immediate forms (csrrwi/csrrsi) are decoded only when YSYX_22050019_CSR_IMM_EN is defined.
module ysyx_22050019_csr_dec
   import ysyx_22050019_csr_pkg::*;
(
   input  logic [31:0] inst_i,
   output logic [7:0]  type_o,
   output logic        wen_o,
   output logic [4:0]  rd_o,
   output logic        rd_wen_o,
   output logic        use_imm_o,
   output logic        illegal_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rs1;

   assign opcode = inst_i[6:0];
   assign funct3 = inst_i[14:12];
   assign rs1    = inst_i[19:15];
   assign rd_o   = inst_i[11:7];

   always_comb begin
      type_o    = '0;
      wen_o     = 1'b0;
      use_imm_o = 1'b0;
      illegal_o = 1'b0;
      if (inst_i == INST_ECALL) begin
         type_o[CSR_T_ECALL] = 1'b1;
      end else if (inst_i == INST_MRET) begin
         type_o[CSR_T_MRET] = 1'b1;
      end else if (opcode != OPC_SYSTEM) begin
         illegal_o = 1'b1;
      end else begin
         case (funct3)
            F3_CSRRW: begin
               type_o[CSR_T_CSRRW] = 1'b1;
               wen_o               = 1'b1;
            end
            // csrrs with rs1 == x0 is a pure read and must not write the CSR
            F3_CSRRS: begin
               type_o[CSR_T_CSRRS] = 1'b1;
               wen_o               = (rs1 != 5'd0);
            end
`ifdef YSYX_22050019_CSR_IMM_EN
            F3_CSRRWI: begin
               type_o[CSR_T_CSRRW] = 1'b1;
               wen_o               = 1'b1;
               use_imm_o           = 1'b1;
            end
            F3_CSRRSI: begin
               type_o[CSR_T_CSRRS] = 1'b1;
               wen_o               = (rs1 != 5'd0);
               use_imm_o           = 1'b1;
            end
`endif
            default: illegal_o = 1'b1;
         endcase
      end
   end

   assign rd_wen_o = (type_o[CSR_T_CSRRW] | type_o[CSR_T_CSRRS]) & (rd_o != 5'd0);

endmodule

// File: rtl/ysyx_22050019_csr_seq.sv
// CSR instruction sequencer: IDLE -> EXEC (one-cycle CSR strobe) -> RESP (hold result until accepted).
// Build with YSYX_22050019_CSR_IMM_EN to accept csrrwi/csrrsi.
module ysyx_22050019_csr_seq
   import ysyx_22050019_csr_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   output logic [7:0]      csr_inst_type,
   output logic [11:0]     csr_addr,
   output logic            csr_wen,
   output logic [XLEN-1:0] csr_pc,
   output logic [XLEN-1:0] csr_src,
   input  logic [XLEN-1:0] csr_rdata,
   input  logic [XLEN-1:0] csr_snpc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_rd,
   output logic            out_rd_wen,
   output logic [XLEN-1:0] out_rd_data,
   output logic            out_illegal,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   csr_state_e      state_q, state_d;
   logic [31:0]     inst_q;
   logic [XLEN-1:0] pc_q, rs1_q;
   logic [4:0]      rd_q;
   logic            rd_wen_q, illegal_q, redir_q;
   logic [XLEN-1:0] rd_data_q, redir_pc_q;

   logic [7:0]      dec_type;
   logic            dec_wen, dec_rd_wen, dec_use_imm, dec_illegal;
   logic [4:0]      dec_rd;
   logic            exec_act, dec_trap;

   ysyx_22050019_csr_dec u_dec (
      .inst_i    (inst_q),
      .type_o    (dec_type),
      .wen_o     (dec_wen),
      .rd_o      (dec_rd),
      .rd_wen_o  (dec_rd_wen),
      .use_imm_o (dec_use_imm),
      .illegal_o (dec_illegal)
   );

   assign dec_trap = dec_type[CSR_T_ECALL] | dec_type[CSR_T_MRET];

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (out_ready) state_d = ST_RESP == state_q ? ST_IDLE : state_q;
         default: state_d = ST_IDLE;
      endcase
   end

   // rst_n gates the strobes combinationally so a reset cycle never shows a CSR write or a handshake
   always_comb begin
      exec_act      = (state_q == ST_EXEC) && rst_n;
      in_ready      = (state_q == ST_IDLE) && rst_n;
      out_valid     = (state_q == ST_RESP) && rst_n;
      csr_inst_type = exec_act ? dec_type : 8'd0;
      csr_wen       = exec_act & dec_wen;
      csr_addr      = exec_act ? inst_q[31:20] : 12'd0;
      csr_pc        = exec_act ? pc_q : '0;
      csr_src       = '0;
      if (exec_act) csr_src = dec_use_imm ? {{(XLEN-5){1'b0}}, inst_q[19:15]} : rs1_q;
   end

   always_ff @(posedge clk) begin
      if (in_ready && in_valid) begin
         inst_q <= in_inst;
         pc_q   <= in_pc;
         rs1_q  <= in_rs1_data;
      end
   end

   // Result capture happens on the EXEC edge, alongside the CSR file commit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q       <= 5'd0;
         rd_wen_q   <= 1'b0;
         illegal_q  <= 1'b0;
         redir_q    <= 1'b0;
         rd_data_q  <= '0;
         redir_pc_q <= '0;
      end else begin
         redir_q <= 1'b0;
         if (state_q == ST_EXEC) begin
            rd_q       <= dec_rd;
            rd_wen_q   <= dec_rd_wen;
            illegal_q  <= dec_illegal;
            rd_data_q  <= dec_illegal ? '0 : csr_rdata;
            redir_q    <= dec_trap;
            redir_pc_q <= dec_trap ? csr_snpc : '0;
         end
      end
   end

   assign out_rd         = rd_q;
   assign out_rd_wen     = rd_wen_q;
   assign out_illegal    = illegal_q;
   assign out_rd_data    = rd_data_q;
   assign redirect_valid = redir_q;
   assign redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_ysyx_22050019_csr_seq.sv
// Directed bench for the CSR sequencer; honours YSYX_22050019_CSR_IMM_EN for the csrrwi vector.
module tb_ysyx_22050019_csr_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc, in_rs1_data;
   logic [7:0]  csr_inst_type;
   logic [11:0] csr_addr;
   logic        csr_wen;
   logic [63:0] csr_pc, csr_src, csr_rdata, csr_snpc;
   logic        out_valid, out_ready;
   logic [4:0]  out_rd;
   logic        out_rd_wen;
   logic [63:0] out_rd_data;
   logic        out_illegal;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_22050019_csr_seq dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_inst        (in_inst),
      .in_pc          (in_pc),
      .in_rs1_data    (in_rs1_data),
      .csr_inst_type  (csr_inst_type),
      .csr_addr       (csr_addr),
      .csr_wen        (csr_wen),
      .csr_pc         (csr_pc),
      .csr_src        (csr_src),
      .csr_rdata      (csr_rdata),
      .csr_snpc       (csr_snpc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_rd         (out_rd),
      .out_rd_wen     (out_rd_wen),
      .out_rd_data    (out_rd_data),
      .out_illegal    (out_illegal),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction from IDLE; returns sitting in the EXEC cycle
   task automatic issue(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] rs1);
      int n = 0;
      while (!in_ready && n < 10) begin
         step();
         n++;
      end
      chk("issue_in_ready", {63'd0, in_ready}, 64'd1);
      in_valid    = 1'b1;
      in_inst     = inst;
      in_pc       = pc;
      in_rs1_data = rs1;
      step();
      in_valid    = 1'b0;
      in_inst     = 32'h0;
      #1;
   endtask

   // Accept the response in the current RESP cycle and land back in IDLE
   task automatic accept();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      #1;
      chk("back_idle", {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = 64'h0; in_rs1_data = 64'h0;
      csr_rdata = 64'h0; csr_snpc = 64'h0; out_ready = 1'b0;
      step(); step();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_redir_valid", {63'd0, redirect_valid}, 64'd0);
      chk("rst_illegal", {63'd0, out_illegal}, 64'd0);
      chk("rst_rd_wen", {63'd0, out_rd_wen}, 64'd0);
      chk("rst_rd_data", out_rd_data, 64'd0);
      chk("rst_redir_pc", redirect_pc, 64'd0);
      chk("rst_type", {56'd0, csr_inst_type}, 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // csrrw x5, mtvec, x6
      csr_rdata = 64'h0; csr_snpc = 64'h1234;
      issue(32'h305312F3, 64'h8000_0010, 64'h8000_0000);
      chk("rw_type", {56'd0, csr_inst_type}, 64'h01);
      chk("rw_wen", {63'd0, csr_wen}, 64'd1);
      chk("rw_addr", {52'd0, csr_addr}, 64'h305);
      chk("rw_src", csr_src, 64'h8000_0000);
      chk("rw_pc", csr_pc, 64'h8000_0010);
      chk("rw_exec_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rw_exec_out_valid", {63'd0, out_valid}, 64'd0);
      step();
      chk("rw_resp_valid", {63'd0, out_valid}, 64'd1);
      chk("rw_rd", {59'd0, out_rd}, 64'd5);
      chk("rw_rd_wen", {63'd0, out_rd_wen}, 64'd1);
      chk("rw_rd_data", out_rd_data, 64'd0);
      chk("rw_no_redir", {63'd0, redirect_valid}, 64'd0);
      chk("rw_resp_bus_type", {56'd0, csr_inst_type}, 64'd0);
      chk("rw_resp_bus_wen", {63'd0, csr_wen}, 64'd0);
      accept();

      // ecall with out_ready held low five cycles
      csr_snpc = 64'h8000_0000; csr_rdata = 64'h77;
      issue(32'h0000_0073, 64'h8000_0100, 64'h0);
      chk("ec_type", {56'd0, csr_inst_type}, 64'h02);
      chk("ec_pc", csr_pc, 64'h8000_0100);
      chk("ec_wen", {63'd0, csr_wen}, 64'd0);
      step();
      chk("ec_redir_valid", {63'd0, redirect_valid}, 64'd1);
      chk("ec_redir_pc", redirect_pc, 64'h8000_0000);
      chk("ec_rd_wen", {63'd0, out_rd_wen}, 64'd0);
      chk("ec_illegal", {63'd0, out_illegal}, 64'd0);
      csr_snpc = 64'hDEAD;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_valid", {63'd0, out_valid}, 64'd1);
         chk("hold_redir_once", {63'd0, redirect_valid}, 64'd0);
         chk("hold_redir_pc", redirect_pc, 64'h8000_0000);
         chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      accept();

      // csrrs x0, mstatus, x0: read only, no writeback
      csr_rdata = 64'hA5A5;
      issue(32'h3000_2073, 64'h8000_0200, 64'hFFFF);
      chk("rs0_type", {56'd0, csr_inst_type}, 64'h04);
      chk("rs0_wen", {63'd0, csr_wen}, 64'd0);
      chk("rs0_addr", {52'd0, csr_addr}, 64'h300);
      step();
      chk("rs0_rd_wen", {63'd0, out_rd_wen}, 64'd0);
      chk("rs0_rd_data", out_rd_data, 64'hA5A5);
      accept();

      // csrrs x7, mscratch, x9
      csr_rdata = 64'h1111_2222_3333_4444;
      issue(32'h3404_A3F3, 64'h8000_0204, 64'h0F0F);
      chk("rs_type", {56'd0, csr_inst_type}, 64'h04);
      chk("rs_wen", {63'd0, csr_wen}, 64'd1);
      chk("rs_src", csr_src, 64'h0F0F);
      step();
      chk("rs_rd", {59'd0, out_rd}, 64'd7);
      chk("rs_rd_wen", {63'd0, out_rd_wen}, 64'd1);
      chk("rs_rd_data", out_rd_data, 64'h1111_2222_3333_4444);
      accept();

      // mret
      csr_snpc = 64'h8000_0044;
      issue(32'h3020_0073, 64'h8000_0300, 64'h0);
      chk("mret_type", {56'd0, csr_inst_type}, 64'h08);
      step();
      chk("mret_redir_valid", {63'd0, redirect_valid}, 64'd1);
      chk("mret_redir_pc", redirect_pc, 64'h8000_0044);
      chk("mret_rd_wen", {63'd0, out_rd_wen}, 64'd0);
      accept();
      chk("mret_redir_drop", {63'd0, redirect_valid}, 64'd0);

      // Non-SYSTEM instruction (add) is illegal
      csr_rdata = 64'hFFFF; csr_snpc = 64'h4444;
      issue(32'h0000_0033, 64'h8000_0400, 64'h5);
      chk("ill_type", {56'd0, csr_inst_type}, 64'd0);
      chk("ill_wen", {63'd0, csr_wen}, 64'd0);
      step();
      chk("ill_flag", {63'd0, out_illegal}, 64'd1);
      chk("ill_redir", {63'd0, redirect_valid}, 64'd0);
      chk("ill_rd_data", out_rd_data, 64'd0);
      chk("ill_rd_wen", {63'd0, out_rd_wen}, 64'd0);
      accept();

      // csrrwi x0, 0x001, 0
      csr_rdata = 64'h9;
      issue(32'h0010_5073, 64'h8000_0500, 64'hABCD);
`ifdef YSYX_22050019_CSR_IMM_EN
      chk("rwi_type", {56'd0, csr_inst_type}, 64'h01);
      chk("rwi_src", csr_src, 64'h0);
      chk("rwi_wen", {63'd0, csr_wen}, 64'd1);
      step();
      chk("rwi_illegal", {63'd0, out_illegal}, 64'd0);
`else
      chk("rwi_type", {56'd0, csr_inst_type}, 64'h00);
      chk("rwi_wen", {63'd0, csr_wen}, 64'd0);
      step();
      chk("rwi_illegal", {63'd0, out_illegal}, 64'd1);
`endif
      accept();

      // Reset while in EXEC: strobe suppressed, IDLE afterwards
      issue(32'h305312F3, 64'h8000_0600, 64'h1);
      rst_n = 1'b0;
      #1;
      chk("rexec_type", {56'd0, csr_inst_type}, 64'd0);
      chk("rexec_wen", {63'd0, csr_wen}, 64'd0);
      step();
      rst_n = 1'b1;
      #1;
      chk("rexec_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rexec_in_ready", {63'd0, in_ready}, 64'd1);

      // Reset while in RESP: result dropped without a handshake
      csr_snpc = 64'h8000_0000;
      issue(32'h0000_0073, 64'h8000_0700, 64'h0);
      step();
      rst_n = 1'b0; out_ready = 1'b1;
      #1;
      chk("rresp_out_valid", {63'd0, out_valid}, 64'd0);
      step();
      rst_n = 1'b1; out_ready = 1'b0;
      #1;
      chk("rresp_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rresp_out_valid2", {63'd0, out_valid}, 64'd0);
      chk("rresp_redir", {63'd0, redirect_valid}, 64'd0);
      chk("rresp_redir_pc", redirect_pc, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_22050019_csr_seq.md
YSYX_22050019_CSR_SEQ -- requirements
Module: ysyx_22050019_csr_seq

Interface
REQ-001 SHALL have no parameters; all widths fixed (XLEN 64, instruction 32).
REQ-002 clk  in  1  clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 in_valid/in_ready  in/out  1/1  upstream handshake; transfer when both high at a posedge.
REQ-005 in_inst/in_pc/in_rs1_data  in  32/64/64  instruction, its PC, and the rs1 value.
REQ-006 csr_inst_type/csr_addr/csr_wen/csr_pc/csr_src  out  8/12/1/64/64  CSR strobe bus; type bit0 csrrw, bit1 ecall, bit2 csrrs, bit3 mret, bits7:4 always 0.
REQ-007 csr_rdata/csr_snpc  in  64/64  old CSR value and trap/return target, combinational from CSR file.
REQ-008 out_valid/out_ready  out/in  1/1  downstream handshake.
REQ-009 out_rd/out_rd_wen/out_rd_data/out_illegal  out  5/1/64/1  writeback result.
REQ-010 redirect_valid/redirect_pc  out  1/64  one-cycle PC redirect for ecall/mret.

Function
REQ-011 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-012 in_ready SHALL be 1 only in IDLE; a transfer latches inst/pc/rs1 and moves to EXEC.
REQ-013 EXEC SHALL last exactly 1 cycle; the CSR bus SHALL be driven only in EXEC and be all-zero in every other state.
REQ-014 Decode: opcode 7'b1110011; funct3 001 csrrw, 010 csrrs; funct3 000 with inst 32'h00000073 ecall, 32'h30200073 mret; everything else illegal.
REQ-015 csr_addr SHALL be inst[31:20]; csr_src SHALL be rs1 data; csr_pc SHALL be latched pc.
REQ-016 csr_wen SHALL be 1 for csrrw; for csrrs only when inst[19:15]!=0; 0 otherwise.
REQ-017 At the EXEC posedge the block SHALL capture csr_rdata as out_rd_data and csr_snpc as the redirect target; the CSR write commits on that same edge.
REQ-018 RESP SHALL hold out_valid=1 and stable outputs until out_ready; it then returns to IDLE. Max throughput 1 instruction per 3 cycles.
REQ-019 out_rd_wen SHALL be 1 for csrrw/csrrs with rd=inst[11:7]!=0; 0 for ecall, mret, illegal.
REQ-020 redirect_valid SHALL pulse exactly one cycle, on the first RESP cycle, for ecall/mret only, with redirect_pc = captured snpc.
REQ-021 Illegal: csr_inst_type stays 0 in EXEC, out_illegal=1, no redirect, out_rd_data=0.

Reset
REQ-022 rst_n=0 at a posedge SHALL force IDLE and out_valid, redirect_valid, out_illegal, out_rd_wen to 0, out_rd_data, redirect_pc to 0, in_ready to 1 after release.
REQ-023 Reset during EXEC SHALL zero the CSR bus that cycle; no CSR write occurs.
REQ-024 Reset during RESP SHALL drop the pending result with no handshake.

Configuration
REQ-025 Macro YSYX_22050019_CSR_IMM_EN: when defined, funct3 101 (csrrwi) and 110 (csrrsi) SHALL decode as type bit0/bit2 with csr_src = zero-extended inst[19:15]; csrrsi csr_wen only when zimm!=0.
REQ-026 Without the macro, funct3 101/110 SHALL be illegal.

Structure
REQ-027 Package ysyx_22050019_csr_pkg SHALL hold CSR type bit indices, SYSTEM opcode, funct3 codes, ECALL/MRET encodings, FSM state enum.
REQ-028 Combinational decoder SHALL be sub-module ysyx_22050019_csr_dec (inst -> type, wen, rd, illegal).

Verification
REQ-029 csrrw x5, mtvec(0x305), x6 with rs1=0x8000_0000, csr_rdata=0 -> EXEC type=0x01 wen=1 addr=0x305; RESP rd=5 wen=1 data=0.
REQ-030 ecall at pc 0x8000_0100, csr_snpc=0x8000_0000 -> EXEC type=0x02 csr_pc=0x8000_0100; redirect pulse 1 cycle pc 0x8000_0000; rd_wen=0.
REQ-031 csrrs x0, mstatus, x0 -> type=0x04 wen=0, rd_wen=0; mret -> type=0x08, redirect to csr_snpc.
REQ-032 out_ready held low 5 cycles -> out_valid/data stable, in_ready=0, redirect single pulse only.
REQ-033 rst_n low during EXEC and during RESP -> no CSR strobe/no out_valid, IDLE next cycle.
REQ-034 inst 0x00105073 (csrrwi): with macro type=0x01 src=0x0...0; without macro out_illegal=1, type=0.
